// File: rtl/apb_downsizer_arbiter.sv
// Two-requester round-robin APB arbiter feeding the 32-bit upstream port of apb_downsizer.
// Optional ACCESS timeout with PSLVERR reporting is enabled by defining APB_ARB_TIMEOUT_EN.
module apb_downsizer_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              psel0,
    input  logic              psel1,
    input  logic              penable0,
    input  logic              penable1,
    input  logic              pwrite0,
    input  logic              pwrite1,
    input  logic [ADDR_W-1:0] paddr0,
    input  logic [ADDR_W-1:0] paddr1,
    input  logic [DATA_W-1:0] pwdata0,
    input  logic [DATA_W-1:0] pwdata1,
    output logic [DATA_W-1:0] prdata0,
    output logic [DATA_W-1:0] prdata1,
    output logic              pready0,
    output logic              pready1,
`ifdef APB_ARB_TIMEOUT_EN
    output logic              pslverr0,
    output logic              pslverr1,
`endif
    output logic              pselo,
    output logic              penableo,
    output logic              pwriteo,
    output logic [ADDR_W-1:0] paddro,
    output logic [DATA_W-1:0] pwdatao,
    input  logic [DATA_W-1:0] prdatai,
    input  logic              preadyi
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t state_r;
    logic   grant_r;
    logic   last_grant_r;
    logic   win_s;
    logic   unused_s;

`ifdef APB_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    logic [CNT_W-1:0] cnt_r;
`endif

    // Requester enables carry no information the arbiter needs; PSEL alone starts a request.
    assign unused_s = &{1'b0, penable0, penable1, TIMEOUT[0]};

    // Round-robin pick: on a tie the requester that was not served last wins.
    always_comb begin
        win_s = 1'b0;
        if (psel0 && psel1) begin
            win_s = ~last_grant_r;
        end else if (psel1) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
    end

    // Arbitration FSM with all downstream and requester outputs registered.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_r      <= ST_IDLE;
            grant_r      <= 1'b0;
            last_grant_r <= 1'b1;
            pselo        <= 1'b0;
            penableo     <= 1'b0;
            pwriteo      <= 1'b0;
            paddro       <= {ADDR_W{1'b0}};
            pwdatao      <= {DATA_W{1'b0}};
            pready0      <= 1'b0;
            pready1      <= 1'b0;
            prdata0      <= {DATA_W{1'b0}};
            prdata1      <= {DATA_W{1'b0}};
`ifdef APB_ARB_TIMEOUT_EN
            pslverr0     <= 1'b0;
            pslverr1     <= 1'b0;
            cnt_r        <= {CNT_W{1'b0}};
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (psel0 || psel1) begin
                        grant_r  <= win_s;
                        pselo    <= 1'b1;
                        penableo <= 1'b0;
                        pwriteo  <= win_s ? pwrite1 : pwrite0;
                        paddro   <= win_s ? paddr1  : paddr0;
                        pwdatao  <= win_s ? pwdata1 : pwdata0;
                        state_r  <= ST_SETUP;
                    end else begin
                        state_r  <= ST_IDLE;
                    end
                end
                ST_SETUP: begin
                    penableo <= 1'b1;
                    state_r  <= ST_ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
                    cnt_r    <= {CNT_W{1'b0}};
`endif
                end
                ST_ACCESS: begin
                    if (preadyi) begin
                        pselo        <= 1'b0;
                        penableo     <= 1'b0;
                        last_grant_r <= grant_r;
                        state_r      <= ST_DONE;
                        if (grant_r) begin
                            pready1 <= 1'b1;
                            prdata1 <= prdatai;
                        end else begin
                            pready0 <= 1'b1;
                            prdata0 <= prdatai;
                        end
                    end
`ifdef APB_ARB_TIMEOUT_EN
                    // Abort after TIMEOUT sampled-low ACCESS cycles; the requester sees an error.
                    else if (cnt_r == CNT_LAST) begin
                        pselo        <= 1'b0;
                        penableo     <= 1'b0;
                        last_grant_r <= grant_r;
                        state_r      <= ST_DONE;
                        if (grant_r) begin
                            pready1  <= 1'b1;
                            pslverr1 <= 1'b1;
                            prdata1  <= {DATA_W{1'b0}};
                        end else begin
                            pready0  <= 1'b1;
                            pslverr0 <= 1'b1;
                            prdata0  <= {DATA_W{1'b0}};
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
`endif
                end
                ST_DONE: begin
                    pready0  <= 1'b0;
                    pready1  <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
                    pslverr0 <= 1'b0;
                    pslverr1 <= 1'b0;
`endif
                    state_r  <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_downsizer_arbiter.sv
// Bench for apb_downsizer_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model. Define APB_ARB_TIMEOUT_EN to exercise the timeout path.
module tb_apb_downsizer_arbiter;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;
`ifdef APB_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic                   pclk;
    logic                   presetn;
    logic [1:0]             psel, penable, pwrite, pready;
    logic [1:0][ADDR_W-1:0] paddr;
    logic [1:0][DATA_W-1:0] pwdata, prdata;
    logic                   pselo, penableo, pwriteo, preadyi;
    logic [ADDR_W-1:0]      paddro;
    logic [DATA_W-1:0]      pwdatao, prdatai;
`ifdef APB_ARB_TIMEOUT_EN
    logic [1:0]             pslverr;
`endif

    int checks   = 0;
    int failures = 0;

    apb_downsizer_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .pclk(pclk), .presetn(presetn),
        .psel0(psel[0]), .psel1(psel[1]),
        .penable0(penable[0]), .penable1(penable[1]),
        .pwrite0(pwrite[0]), .pwrite1(pwrite[1]),
        .paddr0(paddr[0]), .paddr1(paddr[1]),
        .pwdata0(pwdata[0]), .pwdata1(pwdata[1]),
        .prdata0(prdata[0]), .prdata1(prdata[1]),
        .pready0(pready[0]), .pready1(pready[1]),
`ifdef APB_ARB_TIMEOUT_EN
        .pslverr0(pslverr[0]), .pslverr1(pslverr[1]),
`endif
        .pselo(pselo), .penableo(penableo), .pwriteo(pwriteo),
        .paddro(paddro), .pwdatao(pwdatao),
        .prdatai(prdatai), .preadyi(preadyi)
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    // Transaction-level model: which requester owns the bus, how long it has owned it,
    // and whether this cycle is its response cycle.
    int                     m_cur;
    int                     m_age;
    bit                     m_resp, m_err;
    int                     m_last;
    logic                   e_write;
    logic [ADDR_W-1:0]      e_addr;
    logic [DATA_W-1:0]      e_wdata;
    logic [1:0][DATA_W-1:0] e_rdata;

    task automatic model_reset();
        m_cur = -1; m_age = 0; m_resp = 1'b0; m_err = 1'b0; m_last = 1;
        e_write = 1'b0; e_addr = '0; e_wdata = '0; e_rdata = '0;
    endtask

    task automatic model_step();
        int w;
        if (m_resp) begin
            m_resp = 1'b0; m_err = 1'b0; m_cur = -1;
        end else if (m_cur < 0) begin
            if (psel[0] || psel[1]) begin
                w = (psel[0] && psel[1]) ? (1 - m_last) : (psel[0] ? 0 : 1);
                m_cur = w; m_age = 1;
                e_write = pwrite[w]; e_addr = paddr[w]; e_wdata = pwdata[w];
            end
        end else if (m_age == 1) begin
            m_age = 2;
        end else if (preadyi) begin
            e_rdata[m_cur] = prdatai; m_resp = 1'b1; m_last = m_cur;
        end else if (TO_EN && (m_age - 1) >= TIMEOUT) begin
            e_rdata[m_cur] = '0; m_resp = 1'b1; m_err = 1'b1; m_last = m_cur;
        end else begin
            m_age = m_age + 1;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge pclk or negedge presetn);
            if (!presetn) model_reset();
            else model_step();
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to the next falling edge and compare every DUT output with the model.
    task automatic tick();
        bit busy;
        @(negedge pclk);
        busy = (m_cur >= 0) && !m_resp;
        chk("pselo", pselo, busy);
        chk("penableo", penableo, busy && (m_age >= 2));
        chk("pwriteo", pwriteo, e_write);
        chk("paddro", paddro, e_addr);
        chk("pwdatao", pwdatao, e_wdata);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("pready%0d", k), pready[k], m_resp && (m_cur == k));
            chk($sformatf("prdata%0d", k), prdata[k], e_rdata[k]);
`ifdef APB_ARB_TIMEOUT_EN
            chk($sformatf("pslverr%0d", k), pslverr[k], m_resp && m_err && (m_cur == k));
`endif
        end
    endtask

    task automatic do_reset();
        #2 presetn = 1'b0;
        tick();
        tick();
        #2 presetn = 1'b1;
    endtask

    int       n_en, idx, served;
    bit       got;
    bit [1:0] act;
    int       got_order [4];
    int       exp_order [4];

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        presetn = 1'b0; psel = '0; penable = '0; pwrite = '0; paddr = '0; pwdata = '0;
        preadyi = 1'b0; prdatai = '0; act = '0;
        exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 0; exp_order[3] = 1;
        tick();
        chk("rst_pselo", pselo, 1'b0);
        chk("rst_pready", {pready1_val(), pready[0]}, 2'b00);
        chk("rst_prdata0", prdata[0], 32'h0);
        tick();
        #2 presetn = 1'b1;

        // Single write from requester 0 with zero downstream wait states.
        psel[0] = 1'b1; pwrite[0] = 1'b1; paddr[0] = 8'h44; pwdata[0] = 32'h1234_5678; preadyi = 1'b1;
        tick();
        chk("t1_pselo_c1", pselo, 1'b1);
        chk("t1_penableo_c1", penableo, 1'b0);
        penable[0] = 1'b1;
        tick();
        chk("t1_penableo_c2", penableo, 1'b1);
        chk("t1_paddro", paddro, 8'h44);
        chk("t1_pwdatao", pwdatao, 32'h1234_5678);
        chk("t1_pwriteo", pwriteo, 1'b1);
        chk("t1_pready0_c2", pready[0], 1'b0);
        tick();
        chk("t1_pready0_c3", pready[0], 1'b1);
        chk("t1_pready1_c3", pready[1], 1'b0);
        psel[0] = 1'b0; penable[0] = 1'b0;
        tick();
        chk("t1_pready0_c4", pready[0], 1'b0);

        // Read from requester 1 with three downstream wait states.
        psel[1] = 1'b1; pwrite[1] = 1'b0; paddr[1] = 8'h48; preadyi = 1'b0; prdatai = 32'hABCD_1234;
        n_en = 0; got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (pready[1]) begin
                got = 1'b1;
                break;
            end
            if (penableo) n_en++;
            preadyi = (n_en >= 4);
        end
        chk("t2_completed", got, 1'b1);
        chk("t2_penable_cycles", n_en, 4);
        chk("t2_prdata1", prdata[1], 32'hABCD_1234);
        chk("t2_pready0", pready[0], 1'b0);
        psel[1] = 1'b0; prdatai = 32'h0;
        tick();
        chk("t2_pready1_drop", pready[1], 1'b0);
        chk("t2_prdata1_hold", prdata[1], 32'hABCD_1234);

        // Two rounds of simultaneous requests right after reset.
        do_reset();
        idx = 0; preadyi = 1'b1;
        for (int r = 0; r < 2; r++) begin
            psel = 2'b11; pwrite = 2'b01; paddr[0] = 8'h10 + 8'(r); paddr[1] = 8'h20 + 8'(r);
            served = 0;
            for (int i = 0; i < 20 && served < 2; i++) begin
                tick();
                if (pready[0] || pready[1]) begin
                    chk("t3_onehot", pready[0] & pready[1], 1'b0);
                    if (idx < 4) got_order[idx] = pready[1] ? 1 : 0;
                    idx++; served++;
                    if (pready[0]) psel[0] = 1'b0;
                    else psel[1] = 1'b0;
                end
            end
            tick();
        end
        chk("t3_count", idx, 4);
        for (int k = 0; k < 4; k++) chk($sformatf("t3_order%0d", k), got_order[k], exp_order[k]);

        // Reset asserted in the middle of ACCESS.
        psel = 2'b01; pwrite = 2'b00; paddr[0] = 8'h20; preadyi = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (penableo) begin
                got = 1'b1;
                break;
            end
        end
        chk("t4_reached_access", got, 1'b1);
        #2 presetn = 1'b0;
        #1;
        chk("t4_pselo", pselo, 1'b0);
        chk("t4_penableo", penableo, 1'b0);
        chk("t4_pready", pready, 2'b00);
        psel = 2'b00;
        tick();
        tick();
        #2 presetn = 1'b1;
        psel = 2'b11; preadyi = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (pready != 2'b00) begin
                got = 1'b1;
                break;
            end
        end
        chk("t4_first_winner", pready, 2'b01);
        psel[0] = 1'b0;
        for (int i = 0; i < 10 && !pready[1]; i++) tick();
        chk("t4_second_served", pready[1], 1'b1);
        psel[1] = 1'b0;
        tick();

`ifdef APB_ARB_TIMEOUT_EN
        // Downstream never ready: the transfer is aborted with an error.
        psel = 2'b01; pwrite = 2'b00; preadyi = 1'b0; prdatai = 32'hFFFF_0000;
        n_en = 0;
        for (int i = 0; i < TIMEOUT + 10 && !pready[0]; i++) begin
            tick();
            if (penableo) n_en++;
        end
        chk("t5_pready0", pready[0], 1'b1);
        chk("t5_pslverr0", pslverr[0], 1'b1);
        chk("t5_prdata0", prdata[0], 32'h0);
        chk("t5_access_cycles", n_en, TIMEOUT);
        psel[0] = 1'b0;
        tick();
        chk("t5_pslverr0_clr", pslverr[0], 1'b0);
        psel[0] = 1'b1; preadyi = 1'b1; prdatai = 32'h5A5A_A5A5;
        for (int i = 0; i < 10 && !pready[0]; i++) tick();
        chk("t5_ok_pready0", pready[0], 1'b1);
        chk("t5_ok_pslverr0", pslverr[0], 1'b0);
        chk("t5_ok_prdata0", prdata[0], 32'h5A5A_A5A5);
        psel[0] = 1'b0;
        tick();
`endif

        // Randomized traffic from both requesters against a randomly stalling slave.
        act = 2'b00;
        for (int c = 0; c < 3000; c++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                if (act[k] && pready[k]) begin
                    act[k] = 1'b0; psel[k] = 1'b0; penable[k] = 1'b0;
                end else if (act[k]) begin
                    penable[k] = 1'b1;
                end
                if (!act[k] && $urandom_range(0, 2) == 0) begin
                    act[k] = 1'b1; psel[k] = 1'b1; penable[k] = 1'b0;
                    pwrite[k] = 1'($urandom_range(0, 1));
                    paddr[k] = 8'($urandom);
                    pwdata[k] = $urandom;
                end
            end
            preadyi = ($urandom_range(0, 3) != 0);
            prdatai = $urandom;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    function automatic logic pready1_val();
        return pready[1];
    endfunction

endmodule
